// File: rtl/ahbl_splitter_n_pkg.sv
// Shared types and constants for the AHB-Lite address splitter.
package ahbl_splitter_n_pkg;

  localparam int unsigned HADDR_W     = 32;
  localparam int unsigned HDATA_W     = 32;
  localparam int unsigned HTRANS_W    = 2;

  localparam int unsigned DEF_NS      = 7;
  localparam int unsigned DEF_TAG_W   = 4;
  localparam int unsigned DEF_TAG_LSB = 28;
  localparam logic [DEF_NS*DEF_TAG_W-1:0] DEF_TAGS =
    {4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h2, 4'h0};

  typedef enum logic [HTRANS_W-1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } err_state_e;

  // Data-phase response as returned to the master.
  typedef struct packed {
    logic               hready;
    logic               hresp;
    logic [HDATA_W-1:0] hrdata;
  } ahbl_rsp_t;

endpackage

// File: rtl/ahbl_splitter_n_if.sv
// Master-side AHB-Lite signals plus the fanned-out slave-side signals of the splitter.
interface ahbl_splitter_n_if
  import ahbl_splitter_n_pkg::*;
#(
  parameter int unsigned NS = DEF_NS
) ();

  logic [HADDR_W-1:0]    HADDR;
  logic [HTRANS_W-1:0]   HTRANS;
  logic                  HREADY;
  logic                  HRESP;
  logic [HDATA_W-1:0]    HRDATA;
  logic [NS-1:0]         S_HSEL;
  logic [NS*HDATA_W-1:0] S_HRDATA;
  logic [NS-1:0]         S_HREADYOUT;
  logic [NS-1:0]         S_HRESP;
  logic                  BUS_ERR;

  modport slave (
    input  HADDR, HTRANS, S_HRDATA, S_HREADYOUT, S_HRESP,
    output HREADY, HRESP, HRDATA, S_HSEL, BUS_ERR
  );

  modport master (
    output HADDR, HTRANS, S_HRDATA, S_HREADYOUT, S_HRESP,
    input  HREADY, HRESP, HRDATA, S_HSEL, BUS_ERR
  );

endinterface

// File: rtl/ahbl_splitter_n_default_slave.sv
// Default slave for unmapped addresses: two-cycle ERROR response for active
// transfers, zero-wait OKAY otherwise, with a BUS_ERR pulse on the final error cycle.
module ahbl_default_slave
  import ahbl_splitter_n_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_hready,
  input  logic i_trans_act,
  input  logic i_unmapped,
  output logic o_hready,
  output logic o_hresp,
  output logic o_bus_err
);

  err_state_e r_state;
  err_state_e w_state_nxt;
  logic       r_hready;
  logic       r_hresp;
  logic       r_bus_err;
  logic       w_hready_nxt;
  logic       w_hresp_nxt;
  logic       w_bus_err_nxt;
  logic       w_start;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_OK;
      r_hready  <= 1'b1;
      r_hresp   <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_hready  <= w_hready_nxt;
      r_hresp   <= w_hresp_nxt;
      r_bus_err <= w_bus_err_nxt;
    end
  end

  // Outputs are decoded from the next state so they leave the flops aligned with the state.
  always_comb begin
    w_state_nxt   = r_state;
    w_start       = i_hready & i_trans_act & i_unmapped;
    unique case (r_state)
      ST_OK:   if (w_start) w_state_nxt = ST_ERR1;
      ST_ERR1: w_state_nxt = ST_ERR2;
      ST_ERR2: w_state_nxt = w_start ? ST_ERR1 : ST_OK;
      default: w_state_nxt = ST_OK;
    endcase
    w_hready_nxt  = (w_state_nxt != ST_ERR1);
    w_hresp_nxt   = (w_state_nxt != ST_OK);
    w_bus_err_nxt = (w_state_nxt == ST_ERR2);
  end

  assign o_hready  = r_hready;
  assign o_hresp   = r_hresp;
  assign o_bus_err = r_bus_err;

endmodule

// File: rtl/ahbl_splitter_n.sv
// AHB-Lite 1-to-NS splitter: tag-based address decode, data-phase response mux,
// and an internal default slave that answers unmapped addresses.
module ahbl_splitter_n
  import ahbl_splitter_n_pkg::*;
#(
  parameter int unsigned           NS      = DEF_NS,
  parameter int unsigned           TAG_W   = DEF_TAG_W,
  parameter int unsigned           TAG_LSB = DEF_TAG_LSB,
  parameter logic [NS*TAG_W-1:0]   TAGS    = (NS*TAG_W)'(DEF_TAGS)
) (
  input  logic          HCLK,
  input  logic          HRESET,
  ahbl_splitter_n_if.slave bus
);

  logic [TAG_W-1:0] w_tag;
  logic [NS-1:0]    w_sel;
  logic             w_hit;
  logic [NS-1:0]    r_dsel;
  ahbl_rsp_t        w_slv_rsp;
  ahbl_rsp_t        w_def_rsp;
  ahbl_rsp_t        w_rsp;
  logic             w_def_hready;
  logic             w_def_hresp;
  logic             w_def_bus_err;
  logic             w_unused;

  assign w_tag    = bus.HADDR[TAG_LSB +: TAG_W];
  assign w_unused = ^{bus.HADDR, bus.HTRANS[0]};

  // Address decode: lowest matching index wins, no match selects the default slave.
  always_comb begin
    w_sel = '0;
    w_hit = 1'b0;
    for (int unsigned i = 0; i < NS; i++) begin
      if (!w_hit && (TAGS[i*TAG_W +: TAG_W] == w_tag)) begin
        w_sel[i] = 1'b1;
        w_hit    = 1'b1;
      end
    end
  end

  assign bus.S_HSEL = w_sel;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_dsel <= '0;
    end else if (w_rsp.hready) begin
      r_dsel <= w_sel;
    end
  end

  always_comb begin
    w_slv_rsp = '0;
    for (int unsigned i = 0; i < NS; i++) begin
      if (r_dsel[i]) begin
        w_slv_rsp.hready = w_slv_rsp.hready | bus.S_HREADYOUT[i];
        w_slv_rsp.hresp  = w_slv_rsp.hresp  | bus.S_HRESP[i];
        w_slv_rsp.hrdata = w_slv_rsp.hrdata | bus.S_HRDATA[i*HDATA_W +: HDATA_W];
      end
    end
  end

  ahbl_default_slave u_default_slave (
    .i_clk       (HCLK),
    .i_rst       (HRESET),
    .i_hready    (w_rsp.hready),
    .i_trans_act (bus.HTRANS[1]),
    .i_unmapped  (~w_hit),
    .o_hready    (w_def_hready),
    .o_hresp     (w_def_hresp),
    .o_bus_err   (w_def_bus_err)
  );

  assign w_def_rsp = '{hready: w_def_hready, hresp: w_def_hresp, hrdata: '0};
  assign w_rsp     = (r_dsel == '0) ? w_def_rsp : w_slv_rsp;

  assign bus.HREADY  = w_rsp.hready;
  assign bus.HRESP   = w_rsp.hresp;
  assign bus.HRDATA  = w_rsp.hrdata;
  assign bus.BUS_ERR = w_def_bus_err;

endmodule

// File: tb/tb_ahbl_splitter_n.sv
// Directed bench for ahbl_splitter_n with a transfer-level reference model checked every cycle.
module tb_ahbl_splitter_n;
  import ahbl_splitter_n_pkg::*;

  logic HCLK   = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  ahbl_splitter_n_if #(.NS(7)) bus_a ();
  ahbl_splitter_n_if #(.NS(3)) bus_b ();

  ahbl_splitter_n #(.NS(7), .TAG_W(4), .TAG_LSB(28), .TAGS(28'h8765420)) dut_a (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus_a));

  ahbl_splitter_n #(.NS(3), .TAG_W(4), .TAG_LSB(28), .TAGS(12'h331)) dut_b (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus_b));

  int total = 0;
  int bad   = 0;

  int map_tag [7] = '{0, 2, 4, 5, 6, 7, 8};
  int m_owner = -1;   // slave owning the data phase, -1 = default slave
  int m_err   = 0;    // 0 none, 1 first error cycle, 2 second error cycle
  bit m_live  = 1'b0;

  function automatic int decode(logic [31:0] a);
    for (int i = 0; i < 7; i++)
      if (int'(a[31:28]) == map_tag[i]) return i;
    return -1;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: advance one transfer phase per edge.
  always @(posedge HCLK) begin
    logic rdy;
    rdy = (m_owner >= 0) ? bus_a.S_HREADYOUT[m_owner] : (m_err != 1);
    if (HRESET) begin
      m_owner = -1;
      m_err   = 0;
    end else if (rdy) begin
      m_owner = decode(bus_a.HADDR);
      m_err   = (m_owner < 0 && bus_a.HTRANS[1]) ? 1 : 0;
    end else if (m_err == 1) begin
      m_err = 2;
    end
    m_live = 1'b1;
  end

  always @(negedge HCLK) begin
    if (m_live) begin
      logic        e_rdy, e_rsp, e_be;
      logic [31:0] e_dat, e_sel;
      int          d;
      if (m_owner >= 0) begin
        e_rdy = bus_a.S_HREADYOUT[m_owner];
        e_rsp = bus_a.S_HRESP[m_owner];
        e_dat = bus_a.S_HRDATA[m_owner*32 +: 32];
        e_be  = 1'b0;
      end else begin
        e_rdy = (m_err != 1);
        e_rsp = (m_err != 0);
        e_dat = 32'h0;
        e_be  = (m_err == 2);
      end
      d     = decode(bus_a.HADDR);
      e_sel = (d < 0) ? 32'h0 : (32'h1 << d);
      chk("model_hready",  32'(bus_a.HREADY),  32'(e_rdy));
      chk("model_hresp",   32'(bus_a.HRESP),   32'(e_rsp));
      chk("model_hrdata",  bus_a.HRDATA,       e_dat);
      chk("model_bus_err", 32'(bus_a.BUS_ERR), 32'(e_be));
      chk("model_hsel",    32'(bus_a.S_HSEL),  e_sel);
    end
  end

  task automatic next_cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic at_neg();
    @(negedge HCLK);
  endtask

  task automatic drive(logic [1:0] tr, logic [31:0] a);
    bus_a.HTRANS = tr;
    bus_a.HADDR  = a;
  endtask

  task automatic rsp3(string nm, logic r, logic e, logic be);
    chk({nm, "_hready"},  32'(bus_a.HREADY),  32'(r));
    chk({nm, "_hresp"},   32'(bus_a.HRESP),   32'(e));
    chk({nm, "_bus_err"}, 32'(bus_a.BUS_ERR), 32'(be));
  endtask

  initial begin
    drive(2'(HTRANS_IDLE), 32'hF000_0000);
    bus_a.S_HREADYOUT = '1;
    bus_a.S_HRESP     = '0;
    for (int i = 0; i < 7; i++) bus_a.S_HRDATA[i*32 +: 32] = 32'hA0A0_0000 | 32'(i);
    bus_b.HTRANS      = 2'(HTRANS_IDLE);
    bus_b.HADDR       = 32'hF000_0000;
    bus_b.S_HREADYOUT = '1;
    bus_b.S_HRESP     = '0;
    bus_b.S_HRDATA    = {32'h0000_0003, 32'h0000_0002, 32'h0000_0001};

    repeat (2) @(posedge HCLK);
    #1 HRESET = 1'b0;
    at_neg();
    rsp3("reset", 1'b1, 1'b0, 1'b0);
    chk("reset_hrdata", bus_a.HRDATA, 32'h0);

    // Waited read from slave 1
    next_cyc(); drive(2'(HTRANS_NONSEQ), 32'h2000_0010);
    at_neg();   chk("rd_hsel", 32'(bus_a.S_HSEL), 32'h02);
    next_cyc(); drive(2'(HTRANS_IDLE), 32'hF000_0000); bus_a.S_HREADYOUT[1] = 1'b0;
    at_neg();   chk("rd_wait1", 32'(bus_a.HREADY), 32'h0);
    next_cyc();
    at_neg();   chk("rd_wait2", 32'(bus_a.HREADY), 32'h0);
    next_cyc(); bus_a.S_HREADYOUT[1] = 1'b1; bus_a.S_HRDATA[32 +: 32] = 32'hDEAD_BEEF;
    at_neg();   chk("rd_done_hready", 32'(bus_a.HREADY), 32'h1);
                chk("rd_done_hrdata", bus_a.HRDATA, 32'hDEAD_BEEF);
    next_cyc();
    at_neg();   chk("rd_after_hrdata", bus_a.HRDATA, 32'h0);

    // Single decode error
    next_cyc(); drive(2'(HTRANS_NONSEQ), 32'h9000_0000);
    at_neg();   chk("err_hsel", 32'(bus_a.S_HSEL), 32'h0);
    next_cyc(); drive(2'(HTRANS_IDLE), 32'hF000_0000);
    at_neg();   rsp3("err_c1", 1'b0, 1'b1, 1'b0);
    next_cyc();
    at_neg();   rsp3("err_c2", 1'b1, 1'b1, 1'b1);
    next_cyc();
    at_neg();   rsp3("err_done", 1'b1, 1'b0, 1'b0);

    // Back-to-back decode errors
    next_cyc(); drive(2'(HTRANS_NONSEQ), 32'hA000_0000);
    next_cyc();
    at_neg();   rsp3("b2b_c1", 1'b0, 1'b1, 1'b0);
    next_cyc();
    at_neg();   rsp3("b2b_c2", 1'b1, 1'b1, 1'b1);
    next_cyc(); drive(2'(HTRANS_IDLE), 32'hF000_0000);
    at_neg();   rsp3("b2b_c3", 1'b0, 1'b1, 1'b0);
    next_cyc();
    at_neg();   rsp3("b2b_c4", 1'b1, 1'b1, 1'b1);
    next_cyc();
    at_neg();   rsp3("b2b_done", 1'b1, 1'b0, 1'b0);

    // IDLE and BUSY to unmapped space are OKAY
    next_cyc(); drive(2'(HTRANS_BUSY), 32'hF000_0000);
    next_cyc(); drive(2'(HTRANS_IDLE), 32'hF000_0000);
    at_neg();   rsp3("busy_unmapped", 1'b1, 1'b0, 1'b0);
    next_cyc();
    at_neg();   rsp3("idle_unmapped", 1'b1, 1'b0, 1'b0);

    // Slave 1 then slave 2 back-to-back, slave 1 stalls once
    next_cyc(); drive(2'(HTRANS_NONSEQ), 32'h2000_0000);
    next_cyc(); drive(2'(HTRANS_NONSEQ), 32'h4000_0000);
                bus_a.S_HREADYOUT[1] = 1'b0;
                bus_a.S_HRDATA[32 +: 32] = 32'h1111_0000;
                bus_a.S_HRDATA[64 +: 32] = 32'h2222_0000;
    at_neg();   chk("sw_hsel", 32'(bus_a.S_HSEL), 32'h04);
                chk("sw_stall_hready", 32'(bus_a.HREADY), 32'h0);
                chk("sw_stall_hrdata", bus_a.HRDATA, 32'h1111_0000);
    next_cyc(); bus_a.S_HREADYOUT[1] = 1'b1; bus_a.S_HRDATA[32 +: 32] = 32'h1111_0001;
    at_neg();   chk("sw_s1_hrdata", bus_a.HRDATA, 32'h1111_0001);
    next_cyc(); drive(2'(HTRANS_IDLE), 32'hF000_0000);
    at_neg();   chk("sw_s2_hrdata", bus_a.HRDATA, 32'h2222_0000);

    // Mapped address phase during the second error cycle
    next_cyc(); drive(2'(HTRANS_NONSEQ), 32'h9000_0000);
    next_cyc(); drive(2'(HTRANS_IDLE), 32'hF000_0000);
    next_cyc(); drive(2'(HTRANS_NONSEQ), 32'h2000_0000);
    at_neg();   rsp3("err2map_c2", 1'b1, 1'b1, 1'b1);
    next_cyc(); drive(2'(HTRANS_IDLE), 32'hF000_0000); bus_a.S_HRDATA[32 +: 32] = 32'h1234_5678;
    at_neg();   rsp3("err2map_s1", 1'b1, 1'b0, 1'b0);
                chk("err2map_hrdata", bus_a.HRDATA, 32'h1234_5678);

    // Reset during the first error cycle
    next_cyc(); drive(2'(HTRANS_NONSEQ), 32'h9000_0000);
    next_cyc(); drive(2'(HTRANS_IDLE), 32'hF000_0000); HRESET = 1'b1;
    at_neg();   rsp3("rst_err1_pre", 1'b0, 1'b1, 1'b0);
    next_cyc(); HRESET = 1'b0;
    at_neg();   rsp3("rst_err1_post", 1'b1, 1'b0, 1'b0);

    // Reset during the second error cycle
    next_cyc(); drive(2'(HTRANS_NONSEQ), 32'h9000_0000);
    next_cyc(); drive(2'(HTRANS_IDLE), 32'hF000_0000);
    next_cyc(); HRESET = 1'b1;
    at_neg();   rsp3("rst_err2_pre", 1'b1, 1'b1, 1'b1);
    next_cyc(); HRESET = 1'b0;
    at_neg();   rsp3("rst_err2_post", 1'b1, 1'b0, 1'b0);

    // NS=3 with duplicate tag 3 on slaves 1 and 2
    next_cyc(); bus_b.HADDR = 32'h3000_0000;
    at_neg();   chk("dup_hsel", 32'(bus_b.S_HSEL), 32'h2);
    next_cyc(); bus_b.HADDR = 32'h1000_0000;
    at_neg();   chk("dup_hrdata", bus_b.HRDATA, 32'h2);
                chk("dup_hsel_s0", 32'(bus_b.S_HSEL), 32'h1);
    next_cyc(); bus_b.HADDR = 32'h5000_0000;
    at_neg();   chk("dup_hsel_none", 32'(bus_b.S_HSEL), 32'h0);
                chk("dup_hrdata_s0", bus_b.HRDATA, 32'h1);

    next_cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
